// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset main control unit.
// The ALU control decoder imports the same ALUOp encodings from here.
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_J     = 6'd2;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_J);
   endfunction

endpackage

// File: rtl/multicycle_output_decode.sv
// Moore output decode: state (plus MemReady for the FETCH-cycle IR/PC loads)
// to the datapath control word. Unreachable encodings decode to all zeros.
module multicycle_output_decode
   import multicycle_control_pkg::*;
(
   input  state_t state_i,
   input  logic   mem_ready_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      // NOTE: every field gets a default first, so no path through the case can infer a latch.
      ctrl_o = '0;
      unique case (state_i)
         FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = SRCB_FOUR;
            ctrl_o.alu_op    = ALUOP_ADD;
            ctrl_o.pc_source = PCSRC_ALU;
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_write  = mem_ready_i;
         end
         DECODE: begin
            ctrl_o.alu_src_b = SRCB_IMM_SH2;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         MEMADR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         MEMRD: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.i_or_d   = 1'b1;
         end
         MEMWB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
         end
         MEMWR: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.i_or_d    = 1'b1;
         end
         EXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_B;
            ctrl_o.alu_op    = ALUOP_FUNCT;
         end
         RWB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
         end
         BRANCH: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_src_b     = SRCB_B;
            ctrl_o.alu_op        = ALUOP_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PCSRC_ALUOUT;
         end
         JUMP: begin
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = PCSRC_JUMP;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main control FSM: state register and next-state logic, with the
// control word decoded by multicycle_output_decode and forced low during reset.
module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       Illegal
);

   state_t state_q, state_d;
   ctrl_t  ctrl;
   logic   illegal_d;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = FETCH;
      illegal_d = 1'b0;
      unique case (state_q)
         FETCH:  state_d = MemReady ? DECODE : FETCH;
         DECODE: begin
            unique case (Op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXEC;
               OP_BEQ:       state_d = BRANCH;
               OP_J:         state_d = JUMP;
               default: begin
                  state_d   = FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEMADR: state_d = (Op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  state_d = MemReady ? MEMWB : MEMRD;
         MEMWB:  state_d = FETCH;
         MEMWR:  state_d = MemReady ? FETCH : MEMWR;
         EXEC:   state_d = RWB;
         RWB:    state_d = FETCH;
         BRANCH: state_d = FETCH;
         JUMP:   state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   multicycle_output_decode u_output_decode (
      .state_i     (state_q),
      .mem_ready_i (MemReady),
      .ctrl_o      (ctrl)
   );

   // Reset aborts any in-flight access, so nothing may write in a reset cycle.
   always_comb begin
      PCWrite     = ctrl.pc_write      & ~reset;
      PCWriteCond = ctrl.pc_write_cond & ~reset;
      IorD        = ctrl.i_or_d        & ~reset;
      MemRead     = ctrl.mem_read      & ~reset;
      MemWrite    = ctrl.mem_write     & ~reset;
      IRWrite     = ctrl.ir_write      & ~reset;
      MemtoReg    = ctrl.mem_to_reg    & ~reset;
      RegDst      = ctrl.reg_dst       & ~reset;
      RegWrite    = ctrl.reg_write     & ~reset;
      ALUSrcA     = ctrl.alu_src_a     & ~reset;
      ALUSrcB     = ctrl.alu_src_b     & {2{~reset}};
      ALUOp       = ctrl.alu_op        & {2{~reset}};
      PCSource    = ctrl.pc_source     & {2{~reset}};
      Illegal     = illegal_d          & ~reset;
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its states and compares the full control word against hand-derived vectors.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Op;
   logic       MemReady;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
   logic [1:0] ALUSrcB, ALUOp, PCSource;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk         (clk),
      .reset       (reset),
      .Op          (Op),
      .MemReady    (MemReady),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .MemtoReg    (MemtoReg),
      .RegDst      (RegDst),
      .RegWrite    (RegWrite),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .PCSource    (PCSource),
      .Illegal     (Illegal)
   );

   // Word layout: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
   //              RegDst RegWrite ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] Illegal
   logic [16:0] word;
   assign word = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal};

   localparam logic [16:0] W_ZERO    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] W_FETCH_R = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
   localparam logic [16:0] W_FETCH_W = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
   localparam logic [16:0] W_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
   localparam logic [16:0] W_DEC_ILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
   localparam logic [16:0] W_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
   localparam logic [16:0] W_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] W_MEMWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
   localparam logic [16:0] W_MEMWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] W_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
   localparam logic [16:0] W_RWB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
   localparam logic [16:0] W_BRANCH  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
   localparam logic [16:0] W_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;

   task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Apply inputs for one cycle, compare the combinational word mid-cycle, then advance.
   task automatic step(input string tag, input logic rst, input logic [5:0] op,
                       input logic rdy, input logic [16:0] exp);
      reset    = rst;
      Op       = op;
      MemReady = rdy;
      #2;
      check(tag, word, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset    = 1'b1;
      Op       = 6'd0;
      MemReady = 1'b1;
      #1;

      step("reset_c0",     1'b1, 6'd0,  1'b1, W_ZERO);
      step("reset_c1",     1'b1, 6'd0,  1'b1, W_ZERO);

      // R-type: FETCH, DECODE, EXEC, RWB
      step("r_fetch",      1'b0, 6'd0,  1'b1, W_FETCH_R);
      step("r_decode",     1'b0, 6'd0,  1'b1, W_DECODE);
      step("r_exec",       1'b0, 6'd0,  1'b1, W_EXEC);
      step("r_rwb",        1'b0, 6'd0,  1'b1, W_RWB);

      // lw with one FETCH wait and two MEMRD waits
      step("lw_fetch_w",   1'b0, 6'd35, 1'b0, W_FETCH_W);
      step("lw_fetch",     1'b0, 6'd35, 1'b1, W_FETCH_R);
      step("lw_decode",    1'b0, 6'd35, 1'b1, W_DECODE);
      step("lw_memadr",    1'b0, 6'd35, 1'b1, W_MEMADR);
      step("lw_memrd_w0",  1'b0, 6'd35, 1'b0, W_MEMRD);
      step("lw_memrd_w1",  1'b0, 6'd35, 1'b0, W_MEMRD);
      step("lw_memrd",     1'b0, 6'd35, 1'b1, W_MEMRD);
      step("lw_memwb",     1'b0, 6'd35, 1'b0, W_MEMWB);

      // beq
      step("beq_fetch",    1'b0, 6'd4,  1'b1, W_FETCH_R);
      step("beq_decode",   1'b0, 6'd4,  1'b1, W_DECODE);
      step("beq_branch",   1'b0, 6'd4,  1'b1, W_BRANCH);

      // j
      step("j_fetch",      1'b0, 6'd2,  1'b1, W_FETCH_R);
      step("j_decode",     1'b0, 6'd2,  1'b1, W_DECODE);
      step("j_jump",       1'b0, 6'd2,  1'b1, W_JUMP);

      // illegal opcode returns straight to FETCH (checked with MemReady low)
      step("ill_fetch",    1'b0, 6'd63, 1'b1, W_FETCH_R);
      step("ill_decode",   1'b0, 6'd63, 1'b1, W_DEC_ILL);
      step("ill_refetch",  1'b0, 6'd63, 1'b0, W_FETCH_W);

      // sw completing normally after one wait
      step("sw_fetch",     1'b0, 6'd43, 1'b1, W_FETCH_R);
      step("sw_decode",    1'b0, 6'd43, 1'b1, W_DECODE);
      step("sw_memadr",    1'b0, 6'd43, 1'b1, W_MEMADR);
      step("sw_memwr_w0",  1'b0, 6'd43, 1'b0, W_MEMWR);
      step("sw_memwr",     1'b0, 6'd43, 1'b1, W_MEMWR);
      step("sw_next",      1'b0, 6'd43, 1'b0, W_FETCH_W);

      // sw aborted by reset during the second MEMWR wait
      step("swr_fetch",    1'b0, 6'd43, 1'b1, W_FETCH_R);
      step("swr_decode",   1'b0, 6'd43, 1'b1, W_DECODE);
      step("swr_memadr",   1'b0, 6'd43, 1'b1, W_MEMADR);
      step("swr_memwr_w0", 1'b0, 6'd43, 1'b0, W_MEMWR);
      step("swr_reset",    1'b1, 6'd43, 1'b0, W_ZERO);
      step("swr_after",    1'b0, 6'd43, 1'b0, W_FETCH_W);

      // reset and MemReady together in FETCH: reset wins, still FETCH afterwards
      step("rr_reset",     1'b1, 6'd0,  1'b1, W_ZERO);
      step("rr_after",     1'b0, 6'd0,  1'b0, W_FETCH_W);
      step("rr_fetch",     1'b0, 6'd0,  1'b1, W_FETCH_R);
      step("rr_decode",    1'b0, 6'd0,  1'b1, W_DECODE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
